router_out_arb: RTL

ROUTER_OUT_ARB -- requirements
Module: router_out_arb

---
 rtl/router_out_arb.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/router_out_arb.sv
// router_out_arb -- output-channel arbiter for a three-input packet router.
//
// Three show-ahead FIFOs compete for one output channel. Ownership is granted
// round-robin and held for an entire packet (header, L payload words, parity
// word), so packets are never interleaved. A packet whose FIFO stays empty for
// TIMEOUT consecutive cycles is aborted and that FIFO is flushed.
//
// Handshake: a word moves on every cycle where vld_out=1 and out_ready=1. The
// granted FIFO is popped (read_enb_k) on exactly those cycles. vld_out never
// depends on out_ready, and a stalled word (vld_out=1, out_ready=0) stays
// presented unchanged until it is accepted.
//
// Ports:
//   clock                 sole clock, rising edge
//   reset                 synchronous, active-high
//   fifo_empty_0/1/2      FIFO k has no head word
//   data_in_0/1/2  [DW]   show-ahead head word of FIFO k
//   out_ready             downstream accepts data_out this cycle
//   read_enb_0/1/2        pop FIFO k this cycle
//   data_out       [DW]   head word of the granted FIFO, 0 when nothing is granted
//   vld_out               data_out valid
//   grant          [3]    one-hot owner of the channel, 0 when idle
//   pkt_done              one-cycle pulse after a packet's parity word
//   soft_reset_0/1/2      one-cycle pulse flushing FIFO k after a timeout

module router_out_arb #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 30
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          fifo_empty_0,
    input  logic          fifo_empty_1,
    input  logic          fifo_empty_2,
    input  logic [DW-1:0] data_in_0,
    input  logic [DW-1:0] data_in_1,
    input  logic [DW-1:0] data_in_2,
    input  logic          out_ready,
    output logic          read_enb_0,
    output logic          read_enb_1,
    output logic          read_enb_2,
    output logic [DW-1:0] data_out,
    output logic          vld_out,
    output logic [2:0]    grant,
    output logic          pkt_done,
    output logic          soft_reset_0,
    output logic          soft_reset_1,
    output logic          soft_reset_2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [5:0] STARVE_MAX = 6'(TIMEOUT - 1);

    state_t     state_q, state_nxt;
    logic [2:0] grant_q, grant_nxt;
    logic [1:0] gidx_q, gidx_nxt;          // index of the granted FIFO
    logic [1:0] last_q, last_nxt;          // index of the previous owner
    logic [6:0] remaining_q, remaining_nxt;
    logic       hdr_q, hdr_nxt;            // next transfer is the header
    logic [5:0] starve_q, starve_nxt;

    logic [2:0] empty_v;
    logic       g_empty;
    logic       fire;
    logic [1:0] cand0, cand1, cand2;
    logic [1:0] pick;
    logic       pick_vld;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign empty_v = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign g_empty = empty_v[gidx_q];

    // Round-robin search starting one past the previous owner.
    always_comb begin
        cand0    = rr_next(last_q);
        cand1    = rr_next(cand0);
        cand2    = rr_next(cand1);
        pick     = cand0;
        pick_vld = 1'b1;
        if (!empty_v[cand0]) begin
            pick = cand0;
        end else if (!empty_v[cand1]) begin
            pick = cand1;
        end else if (!empty_v[cand2]) begin
            pick = cand2;
        end else begin
            pick_vld = 1'b0;
        end
    end

    // Output datapath: plain mux on the one-hot grant.
    always_comb begin
        data_out = '0;
        case (grant_q)
            3'b001:  data_out = data_in_0;
            3'b010:  data_out = data_in_1;
            3'b100:  data_out = data_in_2;
            default: data_out = '0;
        endcase
    end

    assign grant        = grant_q;
    assign vld_out      = (state_q == XFER) && !g_empty;
    assign fire         = vld_out && out_ready;
    assign read_enb_0   = fire && (gidx_q == 2'd0);
    assign read_enb_1   = fire && (gidx_q == 2'd1);
    assign read_enb_2   = fire && (gidx_q == 2'd2);
    assign pkt_done     = (state_q == DONE);
    assign soft_reset_0 = (state_q == ABORT) && (gidx_q == 2'd0);
    assign soft_reset_1 = (state_q == ABORT) && (gidx_q == 2'd1);
    assign soft_reset_2 = (state_q == ABORT) && (gidx_q == 2'd2);

    always_comb begin
        state_nxt     = state_q;
        grant_nxt     = grant_q;
        gidx_nxt      = gidx_q;
        last_nxt      = last_q;
        remaining_nxt = remaining_q;
        hdr_nxt       = hdr_q;
        starve_nxt    = starve_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt     = XFER;
                    grant_nxt     = 3'b001 << pick;
                    gidx_nxt      = pick;
                    hdr_nxt       = 1'b1;
                    remaining_nxt = '0;
                    starve_nxt    = '0;
                end
            end
            XFER: begin
                if (fire) begin
                    starve_nxt = '0;
                    if (hdr_q) begin
                        // Words still to come after the header: L payload + parity.
                        hdr_nxt       = 1'b0;
                        remaining_nxt = {1'b0, data_out[7:2]} + 7'd1;
                    end else begin
                        // The transfer that takes remaining to zero is the parity word.
                        remaining_nxt = remaining_q - 7'd1;
                        if (remaining_q == 7'd1) begin
                            state_nxt = DONE;
                        end
                    end
                end else if (g_empty) begin
                    if (starve_q == STARVE_MAX) begin
                        state_nxt = ABORT;
                    end else begin
                        starve_nxt = starve_q + 6'd1;
                    end
                end
            end
            DONE, ABORT: begin
                last_nxt  = gidx_q;
                grant_nxt = 3'b000;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 3'b000;
            gidx_q      <= 2'd0;
            last_q      <= 2'd2;
            remaining_q <= '0;
            hdr_q       <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_nxt;
            grant_q     <= grant_nxt;
            gidx_q      <= gidx_nxt;
            last_q      <= last_nxt;
            remaining_q <= remaining_nxt;
            hdr_q       <= hdr_nxt;
            starve_q    <= starve_nxt;
        end
    end

endmodule
